// File: rtl/downsample_pkg.sv
// Shared FMCW parameter set for the decimation stage.
// Provides default sample width and default decimation factor.
package downsample_pkg;

    localparam int DS_OW = 14;
    localparam int DS_M  = 20;

endpackage

// File: rtl/downsample.sv
// Decimates the sample stream by M and produces the slow sample clock.
// Ports: clk_i/rst_n_i fast clock and async active-low reset;
//        data_i input sample; clk_o divided clock (registered);
//        data_o held decimated sample; valid_o one-cycle update strobe.
module downsample
    import downsample_pkg::*;
#(
    parameter int OW = DS_OW,
    parameter int M  = DS_M
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    output logic          clk_o,
    input  logic [OW-1:0] data_i,
    output logic [OW-1:0] data_o,
    output logic          valid_o
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;

    localparam logic [CW-1:0] LAST = CW'(M - 1);
    localparam logic [CW-1:0] HALF = CW'(M / 2);

    if (M < 2) begin : g_bad_m
        $error("downsample: M must be >= 2");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          armed_q;
    logic          armed_d;
    logic          clk_q;
    logic          clk_d;
    logic [OW-1:0] data_q;
    logic [OW-1:0] data_d;
    logic          valid_q;
    logic          valid_d;
    logic          cap;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        // clk_o stays low until the first counter wrap so that the
        // first rising edge opens a full period, never a partial one.
        armed_d = armed_q | (cnt_d == '0);
        clk_d   = armed_d & (cnt_d < HALF);
        cap     = (cnt_d == HALF);
        data_d  = cap ? data_i : data_q;
        valid_d = cap;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
            clk_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign clk_o   = clk_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_downsample.sv
// Directed bench for downsample: M=20 and M=5 instances share stimulus.
// Expected values come from hand-derived closed-form cycle formulas.
module tb_downsample;

    localparam int OW   = 14;
    localparam int MASK = (1 << OW) - 1;

    logic          clk;
    logic          rst_n;
    logic [OW-1:0] data_i;
    logic          clk20;
    logic [OW-1:0] data20;
    logic          valid20;
    logic          clk5;
    logic [OW-1:0] data5;
    logic          valid5;

    int checks;
    int errors;
    int n;
    logic prev20;
    logic prev5;

    downsample #(.OW(OW), .M(20)) u_m20 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .clk_o   (clk20),
        .data_i  (data_i),
        .data_o  (data20),
        .valid_o (valid20)
    );

    downsample #(.OW(OW), .M(5)) u_m5 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .clk_o   (clk5),
        .data_i  (data_i),
        .data_o  (data5),
        .valid_o (valid5)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d",
                     tag, n, got, exp);
        end
    endtask

    // n = number of clk_i edges since reset release; edge k captured k-1.
    task automatic check_cycle();
        int e20;
        int e5;
        e20 = (n < 10) ? 0 : ((((n - 10) / 20) * 20 + 9) & MASK);
        e5  = (n < 2) ? 0 : ((((n - 2) / 5) * 5 + 1) & MASK);
        chk("clk20", 32'(clk20), 32'((n >= 20) && ((n % 20) < 10)));
        chk("valid20", 32'(valid20), 32'((n % 20) == 10));
        chk("data20", 32'(data20), 32'(e20));
        chk("clk5", 32'(clk5), 32'((n >= 5) && ((n % 5) < 2)));
        chk("valid5", 32'(valid5), 32'((n % 5) == 2));
        chk("data5", 32'(data5), 32'(e5));
        if (!prev20 && clk20)
            chk("rise_sample20", 32'(data20), 32'((n - 11) & MASK));
        if (!prev5 && clk5)
            chk("rise_sample5", 32'(data5), 32'((n - 4) & MASK));
        prev20 = clk20;
        prev5  = clk5;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            n++;
            #1;
            data_i = data_i + 1'b1;
            check_cycle();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_clk20"}, 32'(clk20), 32'(0));
        chk({tag, "_data20"}, 32'(data20), 32'(0));
        chk({tag, "_valid20"}, 32'(valid20), 32'(0));
        chk({tag, "_clk5"}, 32'(clk5), 32'(0));
        chk({tag, "_data5"}, 32'(data5), 32'(0));
        chk({tag, "_valid5"}, 32'(valid5), 32'(0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n      = 0;
        prev20 = 1'b0;
        prev5  = 1'b0;
        rst_n  = 1'b0;
        data_i = '0;

        repeat (3) begin
            @(posedge clk);
            #1;
            check_zero("reset");
        end

        @(negedge clk);
        rst_n = 1'b1;
        run(65);

        // Mid-period: clk_o high, data_o = 49; reset must clear now.
        #10;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        check_zero("held_rst");

        data_i = '0;
        n      = 0;
        prev20 = 1'b0;
        prev5  = 1'b0;
        rst_n  = 1'b1;
        run(17000);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
